edlo_cmd_sequencer: RTL

//  Initiator side of the EDLO core pin bus (4b inst, ADDR_BITS addr, 8b data in, 8b result out).

---
 rtl/edlo_pkg.sv | 10 +
 rtl/edlo_cmd_sequencer_if.sv | 28 ++
 rtl/edlo_cmd_fifo.sv | 48 ++++
 rtl/edlo_cmd_sequencer.sv | 91 +++++++++
 4 files changed

// File: rtl/edlo_pkg.sv
// edlo_pkg: shared constants, FSM state type and sizing helper for the EDLO command sequencer
package edlo_pkg;
  localparam logic [3:0] EDLO_NOP    = 4'h0;
  localparam int         EDLO_INST_W = 4;
  localparam int         EDLO_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/edlo_cmd_sequencer_if.sv
// edlo_cmd_sequencer_if: host command, core pin bus and response signals of the sequencer
interface edlo_cmd_sequencer_if import edlo_pkg::*; #(
  parameter int ADDR_BITS = 4
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [EDLO_INST_W-1:0] cmd_inst;
  logic [ADDR_BITS-1:0]   cmd_addr;
  logic [EDLO_DATA_W-1:0] cmd_data;
  logic                   cmd_capture;
  logic [EDLO_INST_W-1:0] bus_inst;
  logic [ADDR_BITS-1:0]   bus_addr;
  logic [EDLO_DATA_W-1:0] bus_data;
  logic [EDLO_DATA_W-1:0] bus_rdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [EDLO_DATA_W-1:0] rsp_data;
  logic [ADDR_BITS-1:0]   rsp_addr;
  logic                   busy;
  modport slave (
    input  cmd_valid, cmd_inst, cmd_addr, cmd_data, cmd_capture, bus_rdata, rsp_ready,
    output cmd_ready, bus_inst, bus_addr, bus_data, rsp_valid, rsp_data, rsp_addr, busy
  );
  modport master (
    output cmd_valid, cmd_inst, cmd_addr, cmd_data, cmd_capture, bus_rdata, rsp_ready,
    input  cmd_ready, bus_inst, bus_addr, bus_data, rsp_valid, rsp_data, rsp_addr, busy
  );
endinterface

// File: rtl/edlo_cmd_fifo.sv
// edlo_cmd_fifo: power-of-two command FIFO; pushes while full are dropped, push+pop keeps count
module edlo_cmd_fifo import edlo_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/edlo_cmd_sequencer.sv
// edlo_cmd_sequencer: buffers host commands and issues them one at a time on the EDLO core pin bus,
// optionally returning the core result RD_LATENCY cycles after each issue cycle.
module edlo_cmd_sequencer import edlo_pkg::*; #(
  parameter int ADDR_BITS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input logic                clk,
  input logic                rst_n,
  edlo_cmd_sequencer_if.slave io
);
  localparam int W  = EDLO_INST_W + ADDR_BITS + EDLO_DATA_W + 1;
  localparam int CW = cnt_w(FIFO_DEPTH);
  seq_state_t             state_q, state_d;
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic                   cap_q, cap_d, rsp_valid_q, rsp_valid_d;
  logic [ADDR_BITS-1:0]   lat_addr_q, lat_addr_d, bus_addr_q, bus_addr_d, rsp_addr_q, rsp_addr_d;
  logic [EDLO_INST_W-1:0] bus_inst_q, bus_inst_d;
  logic [EDLO_DATA_W-1:0] bus_data_q, bus_data_d, rsp_data_q, rsp_data_d;
  logic [EDLO_INST_W-1:0] h_inst;
  logic [ADDR_BITS-1:0]   h_addr;
  logic [EDLO_DATA_W-1:0] h_data;
  logic                   h_cap, pop, fire, full, empty;
  logic [W-1:0]           head;
  logic [CW-1:0]          count;
  edlo_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(io.cmd_valid),
    .pop(pop),
    .din({io.cmd_inst, io.cmd_addr, io.cmd_data, io.cmd_capture}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign {h_inst, h_addr, h_data, h_cap} = head;
  assign io.cmd_ready = !full;
  assign io.busy      = state_q != IDLE || count != '0;
  assign io.bus_inst  = bus_inst_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_data  = bus_data_q;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_data  = rsp_data_q;
  assign io.rsp_addr  = rsp_addr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cap_q       <= 1'b0;
      lat_addr_q  <= '0;
      bus_inst_q  <= EDLO_NOP;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cap_q       <= cap_d;
      lat_addr_q  <= lat_addr_d;
      bus_inst_q  <= bus_inst_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (empty ? IDLE : ISSUE)
            : state_q == ISSUE ? WAIT
            : state_q == WAIT  ? (wait_cnt_q == 4'd1 ? (cap_q ? RESP : IDLE) : WAIT)
            : (io.rsp_ready ? IDLE : RESP);
  end
  // bus registers carry a command only in the cycle after its pop, NOP otherwise
  always_comb begin
    pop         = state_q == IDLE && !empty;
    fire        = state_q == WAIT && wait_cnt_q == 4'd1 && cap_q;
    bus_inst_d  = pop ? h_inst : EDLO_NOP;
    bus_addr_d  = pop ? h_addr : '0;
    bus_data_d  = pop ? h_data : '0;
    cap_d       = pop ? h_cap : cap_q;
    lat_addr_d  = state_q == ISSUE ? bus_addr_q : lat_addr_q;
    wait_cnt_d  = state_q == ISSUE ? 4'(RD_LATENCY) : state_q == WAIT ? wait_cnt_q - 4'd1 : wait_cnt_q;
    rsp_data_d  = fire ? io.bus_rdata : rsp_data_q;
    rsp_addr_d  = fire ? lat_addr_q : rsp_addr_q;
    rsp_valid_d = fire ? 1'b1 : (state_q == RESP && io.rsp_ready) ? 1'b0 : rsp_valid_q;
  end
endmodule
